// File: rtl/compare8.sv
// Registered magnitude comparator: 4-bit slice compares, MSB-first priority, one-hot gt/lt/eq flags.
// Latency PIPE-1 edges after the sampling edge, one compare per clock, no backpressure or hold.
module compare8 #(
   parameter int WIDTH  = 8,
   parameter int SIGNED = 0,
   parameter int PIPE   = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             re,
   output logic             reb,
   output logic             eq
);

   localparam int NS = (WIDTH + 3) / 4;
   localparam int XW = NS * 4;

   logic [XW-1:0] a_x;
   logic [XW-1:0] b_x;
   logic [NS-1:0] gt_d, lt_d;
   logic [NS-1:0] gt_q, lt_q;
   logic          vld_q;
   logic [2:0]    res;

   // Inverting the sign bit maps two's complement onto unsigned order; pad bits are equal zeros.
   always_comb begin
      a_x = '0;
      b_x = '0;
      a_x[WIDTH-1:0] = a;
      b_x[WIDTH-1:0] = b;
      if (SIGNED != 0) begin
         a_x[WIDTH-1] = ~a[WIDTH-1];
         b_x[WIDTH-1] = ~b[WIDTH-1];
      end
   end

   always_comb begin
      gt_d = '0;
      lt_d = '0;
      for (int s = 0; s < NS; s++) begin
         gt_d[s] = a_x[s*4 +: 4] > b_x[s*4 +: 4];
         lt_d[s] = a_x[s*4 +: 4] < b_x[s*4 +: 4];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         gt_q  <= '0;
         lt_q  <= '0;
         vld_q <= 1'b0;
      end else begin
         gt_q  <= gt_d;
         lt_q  <= lt_d;
         vld_q <= 1'b1;
      end
   end

   // Walk LSB to MSB so the most significant decided slice overwrites the rest.
   always_comb begin
      res = 3'b000;
      if (vld_q) begin
         res = 3'b001;
         for (int s = 0; s < NS; s++) begin
            if (gt_q[s] || lt_q[s]) begin
               res = {gt_q[s], lt_q[s], 1'b0};
            end
         end
      end
   end

   generate
      if (PIPE <= 1) begin : g_p1
         assign {re, reb, eq} = res;
      end else begin : g_pn
         logic [2:0] stg_q [2:PIPE];

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               for (int k = 2; k <= PIPE; k++) begin
                  stg_q[k] <= 3'b000;
               end
            end else begin
               stg_q[2] <= res;
               for (int k = 3; k <= PIPE; k++) begin
                  stg_q[k] <= stg_q[k-1];
               end
            end
         end

         assign {re, reb, eq} = stg_q[PIPE];
      end
   endgenerate

endmodule

// File: tb/tb_compare8.sv
// Bench for compare8: directed vectors on three configurations plus a delayed golden-compare scoreboard.
module tb_compare8;

   localparam logic [2:0] GT = 3'b100;
   localparam logic [2:0] LT = 3'b010;
   localparam logic [2:0] EQ = 3'b001;
   localparam logic [2:0] NONE = 3'b000;

   logic       clock;
   logic       reset_n;
   logic [7:0] a, b;
   logic       re0, reb0, eq0;
   logic       re1, reb1, eq1;
   logic       re2, reb2, eq2;

   int n_checks = 0;
   int n_errors = 0;

   // u0: unsigned, PIPE=1.  u1: signed, PIPE=3.  u2: 6-bit signed, PIPE=2.
   compare8 #(.WIDTH(8), .SIGNED(0), .PIPE(1)) u0 (
      .clock(clock), .reset_n(reset_n), .a(a), .b(b), .re(re0), .reb(reb0), .eq(eq0));
   compare8 #(.WIDTH(8), .SIGNED(1), .PIPE(3)) u1 (
      .clock(clock), .reset_n(reset_n), .a(a), .b(b), .re(re1), .reb(reb1), .eq(eq1));
   compare8 #(.WIDTH(6), .SIGNED(1), .PIPE(2)) u2 (
      .clock(clock), .reset_n(reset_n), .a(a[5:0]), .b(b[5:0]), .re(re2), .reb(reb2), .eq(eq2));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [2:0] gold(input logic signed [8:0] x, input logic signed [8:0] y);
      if (x > y) return GT;
      if (x < y) return LT;
      return EQ;
   endfunction

   // Golden results of the operands seen at each rising edge, aged by edge count.
   logic [2:0] h0;
   logic [2:0] h1 [0:2];
   logic [2:0] h2 [0:1];
   int         ecnt;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ecnt  <= 0;
         h0    <= NONE;
         h1[0] <= NONE; h1[1] <= NONE; h1[2] <= NONE;
         h2[0] <= NONE; h2[1] <= NONE;
      end else begin
         ecnt  <= (ecnt < 3) ? ecnt + 1 : 3;
         h0    <= gold({1'b0, a}, {1'b0, b});
         h1[0] <= gold({a[7], a}, {b[7], b});
         h1[1] <= h1[0];
         h1[2] <= h1[1];
         h2[0] <= gold({{3{a[5]}}, a[5:0]}, {{3{b[5]}}, b[5:0]});
         h2[1] <= h2[0];
      end
   end

   task automatic check_flags(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_model();
      check_flags("sb_u0", {re0, reb0, eq0}, (ecnt >= 1) ? h0 : NONE);
      check_flags("sb_u1", {re1, reb1, eq1}, (ecnt >= 3) ? h1[2] : NONE);
      check_flags("sb_u2", {re2, reb2, eq2}, (ecnt >= 2) ? h2[1] : NONE);
      if (ecnt >= 1) check_flags("onehot_u0", {2'b00, $onehot({re0, reb0, eq0})}, 3'b001);
      if (ecnt >= 3) check_flags("onehot_u1", {2'b00, $onehot({re1, reb1, eq1})}, 3'b001);
   endtask

   task automatic tick();
      @(negedge clock);
      check_model();
   endtask

   // a, b, unsigned result, signed result (hand-computed)
   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic [2:0] eu;
      logic [2:0] es;
   } vec_t;

   vec_t vecs [0:8];

   initial begin
      vec_t       v;
      logic [2:0] prev_s;

      vecs[0] = '{8'h80, 8'h7F, GT, LT};
      vecs[1] = '{8'h01, 8'h02, LT, LT};
      vecs[2] = '{8'hFF, 8'hFF, EQ, EQ};
      vecs[3] = '{8'hFF, 8'hFE, GT, GT};
      vecs[4] = '{8'hFF, 8'h00, GT, LT};
      vecs[5] = '{8'hA4, 8'hA5, LT, LT};
      vecs[6] = '{8'hA5, 8'hA4, GT, GT};
      vecs[7] = '{8'h00, 8'h00, EQ, EQ};
      vecs[8] = '{8'h7F, 8'h80, LT, GT};

      reset_n = 1'b0;
      a = 8'h33;
      b = 8'h11;
      repeat (3) tick();
      check_flags("rst_u0", {re0, reb0, eq0}, NONE);
      check_flags("rst_u1", {re1, reb1, eq1}, NONE);
      check_flags("rst_u2", {re2, reb2, eq2}, NONE);

      reset_n = 1'b1;
      a = 8'h05;
      b = 8'h05;
      tick();
      check_flags("fill1_u0", {re0, reb0, eq0}, EQ);
      check_flags("fill1_u1", {re1, reb1, eq1}, NONE);
      tick();
      check_flags("fill2_u1", {re1, reb1, eq1}, NONE);
      tick();
      check_flags("fill3_u1", {re1, reb1, eq1}, EQ);
      prev_s = EQ;

      for (int i = 0; i < 9; i++) begin
         v = vecs[i];
         a = v.va;
         b = v.vb;
         tick();
         check_flags($sformatf("dir%0d_u0", i), {re0, reb0, eq0}, v.eu);
         tick();
         check_flags($sformatf("dir%0d_lat_u1", i), {re1, reb1, eq1}, prev_s);
         tick();
         check_flags($sformatf("dir%0d_u1", i), {re1, reb1, eq1}, v.es);
         prev_s = v.es;
      end

      for (int r = 0; r < 10; r++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         repeat (10) tick();
      end

      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      check_flags("mid_rst_u0", {re0, reb0, eq0}, NONE);
      check_flags("mid_rst_u1", {re1, reb1, eq1}, NONE);
      check_flags("mid_rst_u2", {re2, reb2, eq2}, NONE);
      @(negedge clock);
      reset_n = 1'b1;
      a = 8'hA4;
      b = 8'hA5;
      tick();
      check_flags("refill1_u0", {re0, reb0, eq0}, LT);
      check_flags("refill1_u1", {re1, reb1, eq1}, NONE);
      tick();
      check_flags("refill2_u1", {re1, reb1, eq1}, NONE);
      tick();
      check_flags("refill3_u1", {re1, reb1, eq1}, LT);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
